seg7_reader: RTL

Input-side counterpart of the digit-to-segment encoder. Samples an asynchronous 7-segment pattern bus, for example a loopback of our own display pins or another board's display lines. Waits until the pattern has been stable for a configurable number of cycles, then converts it back to a 4-bit digit. Issues one-cycle event pulses for a newly accepted digit or an illegal pattern, and keeps a saturating error count for the loopback self-test.

---
 rtl/seg7_pkg.sv | 33 +++
 rtl/seg7_pattern_match.sv | 50 +++++
 rtl/seg7_reader.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the 7-segment encoder and reader.
// Contents:
//   SEG_0..SEG_9, SEG_A..SEG_F, SEG_BLANK : segment patterns, bit order
//                                           gfedcba, 1 = segment lit
//   reader_state_t                        : reader FSM states
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b1111100;
  localparam logic [6:0] SEG_C     = 7'b0111001;
  localparam logic [6:0] SEG_D     = 7'b1011110;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_F     = 7'b1110001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    LOCKED
  } reader_state_t;

endpackage

// File: rtl/seg7_pattern_match.sv
// seg7_pattern_match
// Combinational decode of a 7-segment pattern back to its digit value.
// Ports:
//   pattern  in  7 : segment pattern, gfedcba
//   value    out 4 : decoded value (0 when not a digit)
//   is_digit out 1 : pattern is a legal digit
//   is_blank out 1 : pattern is all segments off
// Build option: define SEG7_READER_HEX_EN to also accept A..F (10..15).
module seg7_pattern_match
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       is_digit,
  output logic       is_blank
);

  // Table lookup; anything not listed is neither a digit nor blank.
  always_comb begin
    value    = 4'd0;
    is_digit = 1'b1;
    is_blank = 1'b0;
    case (pattern)
      SEG_0: value = 4'd0;
      SEG_1: value = 4'd1;
      SEG_2: value = 4'd2;
      SEG_3: value = 4'd3;
      SEG_4: value = 4'd4;
      SEG_5: value = 4'd5;
      SEG_6: value = 4'd6;
      SEG_7: value = 4'd7;
      SEG_8: value = 4'd8;
      SEG_9: value = 4'd9;
`ifdef SEG7_READER_HEX_EN
      SEG_A: value = 4'd10;
      SEG_B: value = 4'd11;
      SEG_C: value = 4'd12;
      SEG_D: value = 4'd13;
      SEG_E: value = 4'd14;
      SEG_F: value = 4'd15;
`endif
      SEG_BLANK: begin
        is_digit = 1'b0;
        is_blank = 1'b1;
      end
      default: is_digit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// seg7_reader
// Reads an asynchronous 7-segment bus back into a digit. The bus is
// synchronized, must hold the same value for STABLE_CYCLES samples, and is
// then evaluated once: legal digits update digit, all-off sets blank, and
// anything else pulses pattern_err and bumps a saturating error count.
// A settled pattern equal to the last evaluated one raises no event.
// Ports:
//   clk          in  1 : clock
//   reset        in  1 : synchronous, active high
//   segments_in  in  7 : async pattern, gfedcba, 1 = lit
//   digit        out 4 : last accepted digit
//   digit_valid  out 1 : one-cycle pulse when digit updates
//   pattern_err  out 1 : one-cycle pulse for an illegal settled pattern
//   blank        out 1 : last accepted pattern was all-off
//   err_count    out 4 : saturating count of pattern_err pulses
// Build option: SEG7_READER_HEX_EN (see seg7_pattern_match).
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] segments_in,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       pattern_err,
  output logic       blank,
  output logic [3:0] err_count
);

  localparam logic [7:0] STABLE_LIMIT = 8'(STABLE_CYCLES);

  logic [6:0]    s1, s2;
  logic [6:0]    prev_sample;
  logic [6:0]    last_eval;
  logic          no_eval;
  logic [7:0]    stable_cnt;
  logic [7:0]    run_len;
  logic          evaluate;
  logic          new_pattern;
  reader_state_t state, state_next;
  logic [3:0]    match_value;
  logic          match_digit, match_blank;

  seg7_pattern_match u_match (
    .pattern  (s2),
    .value    (match_value),
    .is_digit (match_digit),
    .is_blank (match_blank)
  );

  // Two-flop synchronizer on the whole bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= segments_in;
      s2 <= s1;
    end
  end

  // Length of the current run of equal s2 samples, counting this one.
  always_comb begin
    if (s2 != prev_sample) begin
      run_len = 8'd1;
    end else if (stable_cnt == 8'hFF) begin
      run_len = 8'hFF;
    end else begin
      run_len = stable_cnt + 8'd1;
    end
  end

  // Next state and the one-shot evaluate strobe. LOCKED can evaluate
  // directly on a change when a single sample is enough to settle.
  always_comb begin
    state_next = state;
    evaluate   = 1'b0;
    case (state)
      IDLE: state_next = SETTLE;
      SETTLE: begin
        if (run_len >= STABLE_LIMIT) begin
          state_next = LOCKED;
          evaluate   = 1'b1;
        end
      end
      LOCKED: begin
        if (s2 != prev_sample) begin
          if (run_len >= STABLE_LIMIT) begin
            evaluate = 1'b1;
          end else begin
            state_next = SETTLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, previous sample and stability counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      prev_sample <= '0;
      stable_cnt  <= '0;
    end else begin
      state       <= state_next;
      prev_sample <= s2;
      stable_cnt  <= (state == IDLE) ? 8'd1 : run_len;
    end
  end

  assign new_pattern = no_eval || (s2 != last_eval);

  // Evaluation of a freshly settled pattern into the output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit       <= '0;
      digit_valid <= 1'b0;
      pattern_err <= 1'b0;
      blank       <= 1'b0;
      err_count   <= '0;
      last_eval   <= '0;
      no_eval     <= 1'b1;
    end else begin
      digit_valid <= 1'b0;
      pattern_err <= 1'b0;
      if (evaluate && new_pattern) begin
        last_eval <= s2;
        no_eval   <= 1'b0;
        if (match_digit) begin
          digit       <= match_value;
          digit_valid <= 1'b1;
          blank       <= 1'b0;
        end else if (match_blank) begin
          blank <= 1'b1;
        end else begin
          pattern_err <= 1'b1;
          if (err_count != 4'hF) begin
            err_count <= err_count + 4'd1;
          end
        end
      end
    end
  end

endmodule
